// File: rtl/sccb_cfg_pkg.sv
// Shared types and constants for the SCCB configuration sequencer.
// The ERR state exists only when CFG_TIMEOUT_EN is defined.
package sccb_cfg_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned WORD_W = 2 * DATA_W;

    localparam logic [WORD_W-1:0] END_MARKER   = 16'hFFFF;
    localparam logic [WORD_W-1:0] DELAY_MARKER = 16'hFFF0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_SEND,
        ST_HOLD,
        ST_WAIT,
        ST_DELAY,
        ST_FIN
`ifdef CFG_TIMEOUT_EN
        , ST_ERR
`endif
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sccb_config_seq_if.sv
// ROM, SCCB-master and status signals of the configuration sequencer.
interface sccb_config_seq_if;
    import sccb_cfg_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] rom_addr;
    logic [WORD_W-1:0] rom_dout;
    logic              sccb_ready;
    logic              sccb_start;
    logic [DATA_W-1:0] sccb_reg;
    logic [DATA_W-1:0] sccb_val;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        input  start, rom_dout, sccb_ready,
        output rom_addr, sccb_start, sccb_reg, sccb_val, busy, done, error
    );

    modport slave (
        output start, rom_dout, sccb_ready,
        input  rom_addr, sccb_start, sccb_reg, sccb_val, busy, done, error
    );
endinterface

// File: rtl/sccb_cycle_timer.sv
// Loadable down-counter that stops at zero; zero_c flags the terminal count.
module sccb_cycle_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);
    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign zero_c = (cnt_q == '0);
endmodule

// File: rtl/sccb_config_seq.sv
// Walks a register/value ROM and issues one SCCB write per entry, honouring delay/end markers.
// Define CFG_TIMEOUT_EN to abort into ERR when the SCCB master stalls for TIMEOUT_CYCLES.
module sccb_config_seq
    import sccb_cfg_pkg::*;
#(
    parameter int unsigned DELAY_CYCLES   = 1_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 65_536
) (
    input  logic              clk,
    input  logic              rst,
    sccb_config_seq_if.master bus
);
    localparam int unsigned CNT_W = $clog2(max_u(DELAY_CYCLES, TIMEOUT_CYCLES) + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              sccb_start_q, sccb_start_d;
    logic [DATA_W-1:0] reg_q, reg_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              last_addr_c;
    logic              idle_like_c;
    logic              dly_load_c;
    logic              dly_dec_c;
    logic              dly_zero_c;

    assign last_addr_c = (rom_addr_q == '1);
    assign dly_load_c  = (state_q == ST_DECODE) && (bus.rom_dout == DELAY_MARKER);
    assign dly_dec_c   = (state_q == ST_DELAY);

    sccb_cycle_timer #(.WIDTH(CNT_W)) u_delay (
        .clk      (clk),
        .rst      (rst),
        .load     (dly_load_c),
        .load_val (CNT_W'(DELAY_CYCLES - 1)),
        .dec      (dly_dec_c),
        .zero_c   (dly_zero_c)
    );

`ifdef CFG_TIMEOUT_EN
    logic to_load_c;
    logic to_dec_c;
    logic to_zero_c;
    logic error_q, error_d;

    // Reload only on entry so the budget covers the whole stay in SEND or WAIT.
    assign to_load_c = (state_d != state_q) && ((state_d == ST_SEND) || (state_d == ST_WAIT));
    assign to_dec_c  = (state_q == ST_SEND) || (state_q == ST_WAIT);
    assign idle_like_c = (state_q == ST_IDLE) || (state_q == ST_FIN) || (state_q == ST_ERR);

    sccb_cycle_timer #(.WIDTH(CNT_W)) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .load     (to_load_c),
        .load_val (CNT_W'(TIMEOUT_CYCLES - 1)),
        .dec      (to_dec_c),
        .zero_c   (to_zero_c)
    );
`else
    assign idle_like_c = (state_q == ST_IDLE) || (state_q == ST_FIN);
`endif

    // State register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rom_addr_q   <= '0;
            sccb_start_q <= 1'b0;
            reg_q        <= '0;
            val_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef CFG_TIMEOUT_EN
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            sccb_start_q <= sccb_start_d;
            reg_q        <= reg_d;
            val_q        <= val_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef CFG_TIMEOUT_EN
            error_q      <= error_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_FIN: if (bus.start) state_d = ST_FETCH;
`ifdef CFG_TIMEOUT_EN
            ST_ERR:          if (bus.start) state_d = ST_FETCH;
`endif
            ST_FETCH:        state_d = ST_DECODE;
            ST_DECODE: begin
                if (bus.rom_dout == END_MARKER)        state_d = ST_FIN;
                else if (bus.rom_dout == DELAY_MARKER) state_d = ST_DELAY;
                else                                   state_d = ST_SEND;
            end
            ST_SEND: begin
                if (bus.sccb_ready) state_d = ST_HOLD;
`ifdef CFG_TIMEOUT_EN
                else if (to_zero_c) state_d = ST_ERR;
`endif
            end
            ST_HOLD:         state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.sccb_ready) state_d = last_addr_c ? ST_FIN : ST_FETCH;
`ifdef CFG_TIMEOUT_EN
                else if (to_zero_c) state_d = ST_ERR;
`endif
            end
            ST_DELAY:        if (dly_zero_c) state_d = last_addr_c ? ST_FIN : ST_FETCH;
            default:         state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, keyed on the transition being taken.
    always_comb begin
        rom_addr_d   = rom_addr_q;
        sccb_start_d = 1'b0;
        reg_d        = reg_q;
        val_d        = val_q;
        busy_d       = busy_q;
        done_d       = done_q;
`ifdef CFG_TIMEOUT_EN
        error_d      = error_q;
`endif
        if (state_d == ST_FETCH) begin
            if (idle_like_c) begin
                rom_addr_d = '0;
                busy_d     = 1'b1;
                done_d     = 1'b0;
`ifdef CFG_TIMEOUT_EN
                error_d    = 1'b0;
`endif
            end else begin
                rom_addr_d = rom_addr_q + ADDR_W'(1);
            end
        end
        if ((state_q == ST_DECODE) && (state_d == ST_SEND)) begin
            reg_d = bus.rom_dout[WORD_W-1:DATA_W];
            val_d = bus.rom_dout[DATA_W-1:0];
        end
        if ((state_q == ST_SEND) && bus.sccb_ready) begin
            sccb_start_d = 1'b1;
        end
        if ((state_d == ST_FIN) && (state_q != ST_FIN)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
`ifdef CFG_TIMEOUT_EN
        if ((state_d == ST_ERR) && (state_q != ST_ERR)) begin
            busy_d  = 1'b0;
            done_d  = 1'b0;
            error_d = 1'b1;
        end
`endif
    end

    assign bus.rom_addr   = rom_addr_q;
    assign bus.sccb_start = sccb_start_q;
    assign bus.sccb_reg   = reg_q;
    assign bus.sccb_val   = val_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
`ifdef CFG_TIMEOUT_EN
    assign bus.error      = error_q;
`else
    assign bus.error      = 1'b0;
`endif
endmodule

// File: tb/tb_sccb_config_seq.sv
// Directed bench for sccb_config_seq with a synchronous ROM model and a pulse monitor.
`timescale 1ns/1ps
module tb_sccb_config_seq;
    import sccb_cfg_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [15:0] rom [256];
    logic [7:0]  pr_reg [$];
    logic [7:0]  pr_val [$];
    int          pr_cyc [$];

    sccb_config_seq_if bus();

    sccb_config_seq #(.DELAY_CYCLES(20), .TIMEOUT_CYCLES(100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ROM with one cycle of read latency
    always @(posedge clk) begin
        cyc          <= cyc + 1;
        bus.rom_dout <= rom[bus.rom_addr];
    end

    always @(negedge clk) begin
        if (bus.sccb_start === 1'b1) begin
            pr_reg.push_back(bus.sccb_reg);
            pr_val.push_back(bus.sccb_val);
            pr_cyc.push_back(cyc);
        end
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        pr_reg.delete();
        pr_val.delete();
        pr_cyc.delete();
    endtask

    task automatic start_seq();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_pulse(input int budget, output int n);
        n = 0;
        while (bus.sccb_start !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic load_two_writes();
        rom[0] = 16'h1280;
        rom[1] = 16'h1100;
        rom[2] = END_MARKER;
    endtask

    initial begin
        int n;
        int s;
        int mism;
        logic [7:0] a;

        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.sccb_ready = 1'b1;
        #2;
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        check("reset error", bus.error, 1'b0);
        check("reset sccb_start", bus.sccb_start, 1'b0);
        check("reset rom_addr", bus.rom_addr, 8'h00);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // two writes then end marker
        load_two_writes();
        clear_log();
        start_seq();
        check("A busy after start", bus.busy, 1'b1);
        check("A done cleared", bus.done, 1'b0);
        wait_done(200, n);
        check("A busy length", n, 12);
        check("A pulse count", pr_reg.size(), 2);
        check("A write0", {pr_reg[0], pr_val[0]}, 16'h1280);
        check("A write1", {pr_reg[1], pr_val[1]}, 16'h1100);
        check("A done", bus.done, 1'b1);
        check("A error", bus.error, 1'b0);

        // delay marker first
        rom[0] = DELAY_MARKER;
        rom[1] = 16'h1180;
        rom[2] = END_MARKER;
        clear_log();
        start_seq();
        s = cyc;
        wait_done(200, n);
        check("B pulse count", pr_reg.size(), 1);
        check("B pulse delay", pr_cyc[0] - s, 25);
        check("B write0", {pr_reg[0], pr_val[0]}, 16'h1180);
        check("B busy length", n, 29);
        check("B done", bus.done, 1'b1);

        // master not ready for 50 cycles in SEND
        rom[0] = 16'h1234;
        rom[1] = END_MARKER;
        clear_log();
        bus.sccb_ready = 1'b0;
        start_seq();
        repeat (50) tick();
        check("C no pulse while stalled", pr_reg.size(), 0);
        check("C busy while stalled", bus.busy, 1'b1);
        check("C error while stalled", bus.error, 1'b0);
        bus.sccb_ready = 1'b1;
        wait_done(50, n);
        check("C pulse count", pr_reg.size(), 1);
        check("C write0", {pr_reg[0], pr_val[0]}, 16'h1234);
        check("C done", bus.done, 1'b1);

        // asynchronous reset while waiting after write 1
        load_two_writes();
        clear_log();
        start_seq();
        wait_pulse(20, n);
        check("D first pulse", bus.sccb_start, 1'b1);
        bus.sccb_ready = 1'b0;
        tick();
        tick();
        check("D reg before reset", bus.sccb_reg, 8'h12);
        #2;
        rst = 1'b1;
        #1;
        check("D reset busy", bus.busy, 1'b0);
        check("D reset reg", bus.sccb_reg, 8'h00);
        check("D reset val", bus.sccb_val, 8'h00);
        check("D reset sccb_start", bus.sccb_start, 1'b0);
        check("D reset rom_addr", bus.rom_addr, 8'h00);
        tick();
        tick();
        rst = 1'b0;
        bus.sccb_ready = 1'b1;
        repeat (20) tick();
        check("D no pulses after reset", pr_reg.size(), 1);
        check("D idle after reset", bus.busy, 1'b0);
        clear_log();
        start_seq();
        check("D restart rom_addr", bus.rom_addr, 8'h00);
        check("D restart busy", bus.busy, 1'b1);
        wait_done(200, n);
        check("D rerun pulse count", pr_reg.size(), 2);
        check("D rerun write0", {pr_reg[0], pr_val[0]}, 16'h1280);

        // full ROM without end marker, plus an ignored start mid-run
        for (int i = 0; i < 256; i++) begin
            a = i[7:0];
            rom[i] = {a, a ^ 8'h5A};
        end
        clear_log();
        start_seq();
        repeat (100) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(2000, n);
        check("E pulse count", pr_reg.size(), 256);
        mism = 0;
        for (int i = 0; i < pr_reg.size(); i++) begin
            a = i[7:0];
            if ({pr_reg[i], pr_val[i]} !== {a, a ^ 8'h5A}) mism++;
        end
        check("E write contents", mism, 0);
        check("E last write", {pr_reg[255], pr_val[255]}, 16'hFFA5);
        check("E final rom_addr", bus.rom_addr, 8'hFF);
        check("E done", bus.done, 1'b1);
        check("E busy", bus.busy, 1'b0);

        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        load_two_writes();
        clear_log();
        start_seq();
        wait_pulse(20, n);
        check("F first pulse", bus.sccb_start, 1'b1);
        bus.sccb_ready = 1'b0;
`ifdef CFG_TIMEOUT_EN
        // master stuck after the first write
        n = 0;
        while (bus.error !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check("F error latency", n, 101);
        check("F error", bus.error, 1'b1);
        check("F busy in ERR", bus.busy, 1'b0);
        check("F done in ERR", bus.done, 1'b0);
        bus.sccb_ready = 1'b1;
        repeat (5) tick();
        check("F error held", bus.error, 1'b1);
        clear_log();
        start_seq();
        check("F error cleared", bus.error, 1'b0);
        check("F busy on rerun", bus.busy, 1'b1);
        wait_done(200, n);
        check("F rerun pulse count", pr_reg.size(), 2);
        check("F rerun done", bus.done, 1'b1);
`else
        // without timeout the block waits indefinitely
        repeat (150) tick();
        check("F error tied low", bus.error, 1'b0);
        check("F still busy", bus.busy, 1'b1);
        check("F single pulse", pr_reg.size(), 1);
        bus.sccb_ready = 1'b1;
        wait_done(50, n);
        check("F pulse count", pr_reg.size(), 2);
        check("F done", bus.done, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
